// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    // Smallest n with 2**n >= value; used to size pointers and the fill count.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on contents.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, FWFT or registered read, fill count,
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = MODE_REG,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        read_data,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [clog2(FIFO_DEPTH):0]   fill_count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A full FIFO rejects writes even when a read is accepted on the same edge.
    always_comb begin
        wr_accept = wr_en && !full_q;
        rd_accept = rd_en && !empty_q;

        wptr_d = wptr_q;
        if (wr_accept) begin
            wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
        end
        rptr_d = rptr_q;
        if (rd_accept) begin
            rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
        end

        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end

        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
        af_d    = (int'(count_d) >= AF_LEVEL);
        ae_d    = (int'(count_d) <= AE_LEVEL);
        ovf_d   = wr_en && full_q;
        unf_d   = rd_en && empty_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wptr_q),
        .wdata (write_data),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is shown straight from storage; zero while nothing is stored.
            assign read_data = empty_q ? '0 : ram_rdata;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (rd_accept) begin
                    rdata_d = ram_rdata;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign read_data = rdata_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign fill_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a 16-deep registered-read instance and a 5-deep FWFT instance,
// checked against queue-based reference models plus an explicit vector table.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_wr, a_rd, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [7:0] a_wdata, a_rdata;
    logic [4:0] a_cnt;

    logic       b_wr, b_rd, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [7:0] b_wdata, b_rdata;
    logic [3:0] b_cnt;

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(MODE_REG)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(a_wr), .write_data(a_wdata), .rd_en(a_rd),
        .read_data(a_rdata), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .fill_count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(MODE_FWFT)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr), .write_data(b_wdata), .rd_en(b_rd),
        .read_data(b_rdata), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .fill_count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic [7:0] a_exp_rd;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] data;
        int         exp_cnt;
        bit         exp_full;
        bit         exp_af;
        bit         exp_ovf;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares one instance's outputs with the reference model state.
    task automatic check_state(
        input string tag, input int depth, input int af_lvl, input int ae_lvl, input int size,
        input logic [31:0] cnt, input logic full, input logic empty, input logic af,
        input logic ae, input logic ovf, input logic unf, input logic [7:0] rdata,
        input logic exp_ovf, input logic exp_unf, input logic [7:0] exp_rdata);
        check({tag, "_cnt"},   cnt,   size);
        check({tag, "_full"},  full,  size == depth);
        check({tag, "_empty"}, empty, size == 0);
        check({tag, "_af"},    af,    size >= af_lvl);
        check({tag, "_ae"},    ae,    size <= ae_lvl);
        check({tag, "_ovf"},   ovf,   exp_ovf);
        check({tag, "_unf"},   unf,   exp_unf);
        check({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    task automatic a_step(input bit wr, input bit rd, input logic [7:0] d);
        logic eo, eu;
        bit   wr_ok, rd_ok;
        a_wr = wr; a_rd = rd; a_wdata = d;
        eo    = wr && (a_q.size() == 16);
        eu    = rd && (a_q.size() == 0);
        wr_ok = wr && (a_q.size() != 16);
        rd_ok = rd && (a_q.size() != 0);
        if (rd_ok) a_exp_rd = a_q.pop_front();
        if (wr_ok) a_q.push_back(d);
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
        $display("A wr=%0b rd=%0b d=%02h -> cnt=%0d rdata=%02h ovf=%0b unf=%0b",
                 wr, rd, d, a_cnt, a_rdata, a_ovf, a_unf);
        check_state("a", 16, 14, 2, a_q.size(), 32'(a_cnt), a_full, a_empty, a_af, a_ae,
                    a_ovf, a_unf, a_rdata, eo, eu, a_exp_rd);
    endtask

    task automatic b_step(input bit wr, input bit rd, input logic [7:0] d);
        logic       eo, eu;
        bit         wr_ok, rd_ok;
        logic [7:0] head;
        b_wr = wr; b_rd = rd; b_wdata = d;
        eo    = wr && (b_q.size() == 5);
        eu    = rd && (b_q.size() == 0);
        wr_ok = wr && (b_q.size() != 5);
        rd_ok = rd && (b_q.size() != 0);
        if (rd_ok) void'(b_q.pop_front());
        if (wr_ok) b_q.push_back(d);
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
        head = (b_q.size() == 0) ? 8'h00 : b_q[0];
        $display("B wr=%0b rd=%0b d=%02h -> cnt=%0d rdata=%02h ovf=%0b unf=%0b",
                 wr, rd, d, b_cnt, b_rdata, b_ovf, b_unf);
        check_state("b", 5, 3, 2, b_q.size(), 32'(b_cnt), b_full, b_empty, b_af, b_ae,
                    b_ovf, b_unf, b_rdata, eo, eu, head);
    endtask

    initial begin
        for (int i = 0; i < 17; i++) begin
            vecs[i] = '{1'b1, 1'b0, 8'(i + 1), (i < 16) ? i + 1 : 16,
                        i >= 15, (i + 1) >= 14, i == 16, 8'h00};
        end
        for (int j = 0; j < 16; j++) begin
            vecs[17 + j] = '{1'b0, 1'b1, 8'h00, 15 - j, 1'b0, (15 - j) >= 14, 1'b0, 8'(j + 1)};
        end

        rst = 1'b1;
        a_wr = 1'b0; a_rd = 1'b0; a_wdata = 8'h00;
        b_wr = 1'b0; b_rd = 1'b0; b_wdata = 8'h00;
        a_exp_rd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_state("rst_a", 16, 14, 2, 0, 32'(a_cnt), a_full, a_empty, a_af, a_ae,
                    a_ovf, a_unf, a_rdata, 1'b0, 1'b0, 8'h00);
        check_state("rst_b", 5, 3, 2, 0, 32'(b_cnt), b_full, b_empty, b_af, b_ae,
                    b_ovf, b_unf, b_rdata, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;

        // Fill 16, attempt a 17th write, then drain in order.
        for (int k = 0; k < 33; k++) begin
            a_step(vecs[k].wr, vecs[k].rd, vecs[k].data);
            check("t1_cnt",   32'(a_cnt), vecs[k].exp_cnt);
            check("t1_full",  a_full,     vecs[k].exp_full);
            check("t1_af",    a_af,       vecs[k].exp_af);
            check("t1_ovf",   a_ovf,      vecs[k].exp_ovf);
            check("t1_rdata", a_rdata,    vecs[k].exp_rdata);
        end

        // Full FIFO with simultaneous write and read.
        for (int k = 0; k < 16; k++) a_step(1'b1, 1'b0, 8'(8'h20 + k));
        a_step(1'b1, 1'b1, 8'hEE);
        check("t3_ovf",   a_ovf,      1);
        check("t3_cnt",   32'(a_cnt), 15);
        check("t3_rdata", a_rdata,    8'h20);

        // Steady state at count 8 with a write and read every cycle.
        for (int k = 0; k < 7; k++) a_step(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 20; k++) begin
            a_step(1'b1, 1'b1, 8'(8'h40 + k));
            check("t4_cnt", 32'(a_cnt), 8);
        end
        for (int k = 0; k < 8; k++) a_step(1'b0, 1'b1, 8'h00);

        // Underflow on an empty FIFO, then an idle cycle to see the pulse end.
        a_step(1'b0, 1'b1, 8'h00);
        check("t5_unf", a_unf, 1);
        a_step(1'b0, 1'b0, 8'h00);

        // Asynchronous reset with six entries stored.
        for (int k = 0; k < 6; k++) a_step(1'b1, 1'b0, 8'(8'h60 + k));
        #2 rst = 1'b1;
        #1;
        check("t5_rst_empty", a_empty,    1);
        check("t5_rst_cnt",   32'(a_cnt), 0);
        check("t5_rst_rdata", a_rdata,    8'h00);
        #1 rst = 1'b0;
        a_q.delete();
        b_q.delete();
        a_exp_rd = 8'h00;
        a_step(1'b1, 1'b0, 8'h77);
        a_step(1'b0, 1'b1, 8'h00);

        // Non-power-of-two depth in FWFT mode across pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) b_step(1'b1, 1'b0, 8'(8'hA0 + r * 5 + k));
            b_step(1'b1, 1'b0, 8'hFF);
            check("t2_ovf", b_ovf, 1);
            for (int k = 0; k < 5; k++) begin
                check("t2_head", b_rdata, 8'(8'hA0 + r * 5 + k));
                b_step(1'b0, 1'b1, 8'h00);
            end
            check("t2_empty_rdata", b_rdata, 8'h00);
        end
        b_step(1'b0, 1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
